// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit for the EXE stage. Multiplies finish after a fixed
// countdown; divides run a restoring 1-bit/cycle loop on operand magnitudes.
module muldiv_unit #(
   parameter int WIDTH      = 32,
   parameter int MUL_STAGES = 2,
   parameter int DIV_EARLY  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             wr_disable,
   input  logic             flush,
   input  logic             accept,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] src1_q, src2_q;
   logic             is_signed_q, div_zero_q, neg_quot_q, neg_rem_q;
   logic [WIDTH-1:0] rem_q, quot_q, dvs_q;

   logic is_mul, is_div, req_signed, launch, commit_ok, div_by_zero;
   assign is_mul      = (op == OP_MULT) || (op == OP_MULTU);
   assign is_div      = (op == OP_DIV) || (op == OP_DIVU);
   assign req_signed  = (op == OP_MULT) || (op == OP_DIV);
   assign div_by_zero = (src2 == '0);
   assign launch      = (state == IDLE) && req_valid && !flush && (is_mul || is_div);
   assign commit_ok   = !wr_disable && !flush;

   // Moves and NOPs complete in the cycle they are presented.
   assign done   = !flush && (((state == IDLE) && req_valid && !is_mul && !is_div) ||
                              (state == DONE));
   assign result = (done && (state == IDLE) && (op == OP_MFHI)) ? hi :
                   (done && (state == IDLE) && (op == OP_MFLO)) ? lo : '0;
   assign busy   = (state != IDLE);

   logic [2*WIDTH-1:0] mul_a, mul_b, product;
   assign mul_a   = {{WIDTH{is_signed_q & src1_q[WIDTH-1]}}, src1_q};
   assign mul_b   = {{WIDTH{is_signed_q & src2_q[WIDTH-1]}}, src2_q};
   assign product = mul_a * mul_b;

   // One restoring step; the final cycle commits straight from these next values.
   logic [WIDTH:0]   div_shift, div_diff;
   logic             div_fit;
   logic [WIDTH-1:0] rem_nxt, quot_nxt, div_hi, div_lo;
   assign div_shift = {rem_q, quot_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, dvs_q};
   assign div_fit   = (div_shift >= {1'b0, dvs_q});
   assign rem_nxt   = div_fit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign quot_nxt  = {quot_q[WIDTH-2:0], div_fit};
   assign div_lo    = div_zero_q ? '1 : cond_negate(quot_nxt, neg_quot_q);
   assign div_hi    = div_zero_q ? src1_q : cond_negate(rem_nxt, neg_rem_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         hi          <= '0;
         lo          <= '0;
         src1_q      <= '0;
         src2_q      <= '0;
         is_signed_q <= 1'b0;
         div_zero_q  <= 1'b0;
         neg_quot_q  <= 1'b0;
         neg_rem_q   <= 1'b0;
         rem_q       <= '0;
         quot_q      <= '0;
         dvs_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (launch) begin
                  src1_q      <= src1;
                  src2_q      <= src2;
                  is_signed_q <= req_signed;
                  if (is_mul) begin
                     state <= MUL;
                     cnt   <= CNT_W'(MUL_STAGES - 1);
                  end else begin
                     state      <= DIV;
                     cnt        <= (div_by_zero && (DIV_EARLY != 0)) ? '0 : CNT_W'(WIDTH - 1);
                     div_zero_q <= div_by_zero;
                     neg_quot_q <= req_signed && (src1[WIDTH-1] ^ src2[WIDTH-1]);
                     neg_rem_q  <= req_signed && src1[WIDTH-1];
                     rem_q      <= '0;
                     quot_q     <= magnitude(src1, req_signed);
                     dvs_q      <= magnitude(src2, req_signed);
                  end
               end else if (req_valid && accept && commit_ok) begin
                  if (op == OP_MTHI) hi <= src1;
                  if (op == OP_MTLO) lo <= src1;
               end
            end
            MUL: begin
               if (cnt == '0) begin
                  if (commit_ok) {hi, lo} <= product;
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DIV: begin
               rem_q  <= rem_nxt;
               quot_q <= quot_nxt;
               if (cnt == '0) begin
                  if (commit_ok) begin
                     hi <= div_hi;
                     lo <= div_lo;
                  end
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (accept || !req_valid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (flush) state <= IDLE;
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit with an arithmetic reference model.
module tb_muldiv_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset, req_valid, wr_disable, flush, accept;
   logic [3:0]    op;
   logic [W-1:0]  src1, src2, result, hi, lo;
   logic          done, busy;

   muldiv_unit #(.WIDTH(W), .MUL_STAGES(2), .DIV_EARLY(1)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .op(op), .src1(src1), .src2(src2),
      .wr_disable(wr_disable), .flush(flush), .accept(accept), .done(done),
      .result(result), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
      int          issue;
   } exp_t;

   exp_t        q[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   bit          armed = 1'b1;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: one pop per completed op; a held done does not count again until accepted.
   initial begin
      exp_t e;
      logic pend;
      forever begin
         @(posedge clk);
         cyc++;
         if (accept || !req_valid) armed = 1'b1;
         @(negedge clk);
         if (done && armed) begin
            armed = 1'b0;
            pend  = (q.size() != 0);
            chk("done_expected", 64'(pend), 64'd1);
            if (pend) begin
               e = q.pop_front();
               chk("result", 64'(result), 64'(e.res));
               chk("hi", 64'(hi), 64'(e.hi));
               chk("lo", 64'(lo), 64'(e.lo));
               chk("latency", 64'(cyc - e.issue), 64'(e.lat));
            end
         end
      end
   end

   function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] nh, output logic [31:0] nl,
                                 output bit lng, output int lat);
      longint pa, pb;
      logic [63:0] p;
      int sa, sb;
      nh = '0; nl = '0; lng = 1'b1; lat = 33;
      case (o)
         4'd1: begin pa = $signed(a); pb = $signed(b); p = pa * pb; {nh, nl} = p; lat = 3; end
         4'd2: begin p = {32'b0, a} * {32'b0, b}; {nh, nl} = p; lat = 3; end
         4'd3: begin
            if (b == 0) begin nh = a; nl = '1; lat = 2; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin nh = '0; nl = a; end
            else begin sa = a; sb = b; nl = sa / sb; nh = sa % sb; end
         end
         4'd4: begin
            if (b == 0) begin nh = a; nl = '1; lat = 2; end
            else begin nl = a / b; nh = a % b; end
         end
         default: begin lng = 1'b0; lat = 0; end
      endcase
   endfunction

   task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit wd, input int hold);
      exp_t e;
      logic [31:0] nh, nl;
      bit lng;
      int lat, t;
      model(o, a, b, nh, nl, lng, lat);
      e.res = (o == 4'd5) ? m_hi : (o == 4'd6) ? m_lo : '0;
      if (lng) begin
         if (!wd) begin m_hi = nh; m_lo = nl; end
         e.hi = m_hi; e.lo = m_lo;
      end else begin
         e.hi = m_hi; e.lo = m_lo;
         if (!wd && o == 4'd7) m_hi = a;
         if (!wd && o == 4'd8) m_lo = a;
      end
      e.lat = lat; e.issue = cyc;
      q.push_back(e);
      req_valid = 1'b1; op = o; src1 = a; src2 = b; wr_disable = wd;
      t = 0;
      do begin @(negedge clk); #1; t++; end while (!done && t < 100);
      chk("done_seen", 64'(done), 64'd1);
      repeat (hold) @(posedge clk);
      if (hold > 0) #1;
      accept = 1'b1;
      @(posedge clk); #1;
      accept = 1'b0; req_valid = 1'b0; wr_disable = 1'b0; op = '0;
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] o;
      int k;
      reset = 1'b1; req_valid = 1'b0; wr_disable = 1'b0; flush = 1'b0; accept = 1'b0;
      op = '0; src1 = '0; src2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
      do_op(4'd6, 32'd0, 32'd0, 1'b0, 0);
      do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
      do_op(4'd4, 32'd7, 32'd2, 1'b0, 1);
      do_op(4'd5, 32'd0, 32'd0, 1'b0, 2);
      do_op(4'd4, 32'd5, 32'd0, 1'b0, 0);
      do_op(4'd3, 32'hFFFF_FFFB, 32'd0, 1'b0, 0);

      // Flush a divide mid-flight with req_valid still high.
      req_valid = 1'b1; op = 4'd3; src1 = 32'd100; src2 = 32'd7;
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("pre_flush_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_done", 64'(done), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_hi", 64'(hi), 64'(m_hi));
      chk("flush_lo", 64'(lo), 64'(m_lo));
      @(posedge clk); #1;
      do_op(4'd1, 32'd6, 32'd7, 1'b0, 0);

      do_op(4'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0);
      do_op(4'd7, 32'h1234, 32'd0, 1'b1, 0);
      do_op(4'd7, 32'h1234, 32'd0, 1'b0, 0);
      do_op(4'd5, 32'd0, 32'd0, 1'b0, 0);
      do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
      do_op(4'd0, 32'd1, 32'd2, 1'b0, 0);
      do_op(4'd12, 32'd1, 32'd2, 1'b0, 1);
      do_op(4'd8, 32'hCAFE_F00D, 32'd0, 1'b0, 0);
      do_op(4'd6, 32'd0, 32'd0, 1'b0, 0);

      for (int i = 0; i < 200; i++) begin
         k = $urandom_range(0, 9);
         if (k < 6) o = 4'(1 + (k % 4));
         else if (k < 9) o = 4'($urandom_range(5, 8));
         else o = 4'($urandom_range(9, 15));
         do_op(o, rnd_val(), rnd_val(), ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
      end

      // Reset in the middle of a divide clears HI/LO.
      req_valid = 1'b1; op = 4'd3; src1 = 32'd1000; src2 = 32'd3;
      repeat (5) @(posedge clk);
      #1; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; req_valid = 1'b0;
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_hi", 64'(hi), 64'd0);
      chk("midrst_lo", 64'(lo), 64'd0);
      @(posedge clk); #1;
      do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);

      repeat (3) @(posedge clk);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
